// File: rtl/conv_encoder_param.sv
// Rate-1/2 convolutional encoder with runtime constraint length and generators.
// Frames are framed by start/frame_len and terminated by a K-1 symbol zero tail.
module conv_encoder_param #(
  parameter int unsigned K_MAX = 7,
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       choose_constraint_length,
  input  logic [K_MAX-1:0] g0,
  input  logic [K_MAX-1:0] g1,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned KW = $clog2(K_MAX + 1);

  typedef enum logic [1:0] {StIdle, StData, StTail} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d, k_sel;
  logic [K_MAX-1:0] g0_q, g0_d, g1_q, g1_d, gmask, win;
  logic [K_MAX-2:0] sr_q, sr_d, sr_mask;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic [1:0]       out_q, out_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic             free, step, cur_bit, tail_done;

  always_comb begin
    if (int'(choose_constraint_length) + 3 > int'(K_MAX)) k_sel = KW'(K_MAX);
    else k_sel = KW'(choose_constraint_length) + KW'(3);
    for (int unsigned i = 0; i < K_MAX; i++) gmask[i] = (i < 32'(k_sel));
    // Only the K-1 youngest history bits are kept so the tail flushes to zero.
    for (int unsigned i = 0; i < K_MAX - 1; i++) sr_mask[i] = (i + 1 < 32'(k_q));
  end

  assign free      = !out_valid_q || out_ready;
  assign step      = ((state_q == StData) && in_valid && free) || ((state_q == StTail) && free);
  assign cur_bit   = (state_q == StData) ? in_bit : 1'b0;
  assign win       = {sr_q, cur_bit};
  assign tail_done = (state_q == StTail) && (cnt_q == (LEN_W'(k_q) - LEN_W'(2)));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    g0_d        = g0_q;
    g1_d        = g1_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (step) begin
      out_d       = {^(g1_q & win), ^(g0_q & win)};
      out_valid_d = 1'b1;
      out_last_d  = tail_done;
      sr_d        = {sr_q[K_MAX-3:0], cur_bit} & sr_mask;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_d     = k_sel;
          g0_d    = g0 & gmask;
          g1_d    = g1 & gmask;
          len_d   = (frame_len == '0) ? LEN_W'(1) : frame_len;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (step) begin
          if (cnt_q == len_q - LEN_W'(1)) begin
            cnt_d   = '0;
            state_d = StTail;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      StTail: begin
        if (step) begin
          if (tail_done) state_d = StIdle;
          else cnt_d = cnt_q + LEN_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      k_q         <= '0;
      g0_q        <= '0;
      g1_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      g0_q        <= g0_d;
      g1_q        <= g1_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = (state_q == StData) && free;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);

endmodule
